// File: rtl/snax_csr_arbiter.sv
// Round-robin arbiter that merges NumReq CSR requesters onto one downstream CSR port.
// An index FIFO records who issued each accepted read, so that read responses go back to that requester in order.
module snax_csr_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CsrAddrWidth   = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0][31:0]             req_data_i,
  input  logic [NumReq-1:0][CsrAddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]                   req_write_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  output logic [31:0]                         rsp_data_o,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic [31:0]                         snax_csr_req_bits_data_o,
  output logic [CsrAddrWidth-1:0]             snax_csr_req_bits_addr_o,
  output logic                                snax_csr_req_bits_write_o,
  output logic                                snax_csr_req_valid_o,
  input  logic                                snax_csr_req_ready_i,
  input  logic [31:0]                         snax_csr_rsp_bits_data_i,
  input  logic                                snax_csr_rsp_valid_i,
  output logic                                snax_csr_rsp_ready_o,
  output logic                                unexpected_rsp_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] prio_q, prio_d;
  logic [IdxW-1:0] grant_q, grant_d;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] mem_q [MaxOutstanding];
  logic            unexpected_q;

  logic [NumReq-1:0] eligible;
  logic [IdxW-1:0]   rr_idx, cand, grant_idx, head_idx;
  logic              rr_found, grant_vld;
  logic              req_hs, push, pop, empty, full;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == MaxCnt);
  assign head_idx = mem_q[rd_ptr_q];

  // Reads are held back while the tracker is full; writes need no tracker slot.
  assign eligible = req_valid_i & (req_write_i | {NumReq{~full}});

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    rr_idx   = prio_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdxW'((32'(prio_q) + k) % NumReq);
      if (!rr_found && eligible[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign grant_idx = (state_q == LOCKED) ? grant_q : rr_idx;
  assign grant_vld = (state_q == LOCKED) | rr_found;
  assign req_hs    = snax_csr_req_valid_o & snax_csr_req_ready_i;
  assign push      = req_hs & ~snax_csr_req_bits_write_o;
  assign pop       = snax_csr_rsp_valid_i & snax_csr_rsp_ready_o & ~empty;

  // State register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        grant_d = rr_idx;
        if (rr_found && !req_hs) state_d = LOCKED;
      end
      LOCKED: if (req_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (req_hs) prio_d = (grant_idx == LastIdx) ? '0 : grant_idx + IdxW'(1);
  end

  // Output logic; handshake outputs stay low while reset is asserted.
  always_comb begin
    snax_csr_req_valid_o      = rst_ni & grant_vld & req_valid_i[grant_idx];
    snax_csr_req_bits_data_o  = req_data_i[grant_idx];
    snax_csr_req_bits_addr_o  = req_addr_i[grant_idx];
    snax_csr_req_bits_write_o = req_write_i[grant_idx];
    req_ready_o               = '0;
    if (rst_ni && grant_vld) req_ready_o[grant_idx] = snax_csr_req_ready_i;

    rsp_valid_o          = '0;
    rsp_data_o           = '0;
    snax_csr_rsp_ready_o = 1'b0;
    if (rst_ni) begin
      rsp_data_o = snax_csr_rsp_bits_data_i;
      if (empty) begin
        // Orphan responses are drained so that the downstream port cannot stall.
        snax_csr_rsp_ready_o = 1'b1;
      end else begin
        rsp_valid_o[head_idx] = snax_csr_rsp_valid_i;
        snax_csr_rsp_ready_o  = rsp_ready_i[head_idx];
      end
    end
  end

  // Tracker pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      unexpected_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      unexpected_q <= snax_csr_rsp_valid_i & empty;
    end
  end

  // NOTE: tracker storage has no reset; only entries counted by cnt_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

  assign unexpected_rsp_o = unexpected_q;

endmodule

// File: tb/tb_snax_csr_arbiter.sv
// Randomised and directed scoreboard bench for snax_csr_arbiter.
// A queue-based model predicts grants, response routing and orphan pulses.
module tb_snax_csr_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int AW   = 32;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [N-1:0][31:0] req_data_i;
  logic [N-1:0][AW-1:0] req_addr_i;
  logic [N-1:0] req_write_i, req_valid_i, req_ready_o;
  logic [31:0]  rsp_data_o;
  logic [N-1:0] rsp_valid_o, rsp_ready_i;
  logic [31:0]  snax_csr_req_bits_data_o;
  logic [AW-1:0] snax_csr_req_bits_addr_o;
  logic snax_csr_req_bits_write_o, snax_csr_req_valid_o, snax_csr_req_ready_i;
  logic [31:0] snax_csr_rsp_bits_data_i;
  logic snax_csr_rsp_valid_i, snax_csr_rsp_ready_o, unexpected_rsp_o;

  snax_csr_arbiter #(.NumReq(N), .MaxOutstanding(MAXO), .CsrAddrWidth(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_data_i(req_data_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .snax_csr_req_bits_data_o(snax_csr_req_bits_data_o),
    .snax_csr_req_bits_addr_o(snax_csr_req_bits_addr_o),
    .snax_csr_req_bits_write_o(snax_csr_req_bits_write_o),
    .snax_csr_req_valid_o(snax_csr_req_valid_o), .snax_csr_req_ready_i(snax_csr_req_ready_i),
    .snax_csr_rsp_bits_data_i(snax_csr_rsp_bits_data_i),
    .snax_csr_rsp_valid_i(snax_csr_rsp_valid_i), .snax_csr_rsp_ready_o(snax_csr_rsp_ready_o),
    .unexpected_rsp_o(unexpected_rsp_o)
  );

  typedef struct { int cyc; int idx; logic [31:0] addr; logic [31:0] data; logic wr; } req_exp_t;
  typedef struct { int cyc; logic [N-1:0] vld; logic [31:0] data; logic rdy; } rsp_exp_t;

  req_exp_t exp_req_q[$];
  rsp_exp_t exp_rsp_q[$];
  int       exp_unx_q[$];

  // Model state: requester intents, outstanding read owners, lock and last winner.
  bit          pend_v [N];
  bit          pend_w [N];
  logic [31:0] pend_a [N];
  logic [31:0] pend_d [N];
  int outst[$];
  int locked = -1;
  int last   = -1;

  bit          d_ready, d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [N-1:0] d_rsp_ready;

  int cyc = 0;
  bit mon_en = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(int i, bit w, logic [31:0] a, logic [31:0] d);
    pend_v[i] = 1'b1;
    pend_w[i] = w;
    pend_a[i] = a;
    pend_d[i] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    outst.delete();
    exp_req_q.delete();
    exp_rsp_q.delete();
    exp_unx_q.delete();
    locked = -1;
    last   = -1;
  endtask

  // Drive one cycle, predict its outcome, then advance to just after the next edge.
  task automatic step();
    int g;
    int h;
    req_exp_t re;
    rsp_exp_t se;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = pend_v[i];
      req_write_i[i] = pend_w[i];
      req_addr_i[i]  = pend_a[i];
      req_data_i[i]  = pend_d[i];
    end
    snax_csr_req_ready_i     = d_ready;
    snax_csr_rsp_valid_i     = d_rsp_valid;
    snax_csr_rsp_bits_data_i = d_rsp_data;
    rsp_ready_i              = d_rsp_ready;

    g = -1;
    if (locked >= 0) g = locked;
    else
      for (int k = 0; k < N; k++) begin
        int i;
        i = (last + 1 + k) % N;
        if (g < 0 && pend_v[i] && (pend_w[i] || outst.size() < MAXO)) g = i;
      end

    if (g >= 0 && d_ready) begin
      re.cyc = cyc; re.idx = g; re.addr = pend_a[g]; re.data = pend_d[g]; re.wr = pend_w[g];
      exp_req_q.push_back(re);
    end else if (g >= 0) begin
      locked = g;
    end

    if (d_rsp_valid) begin
      se.cyc = cyc; se.data = d_rsp_data; se.vld = '0;
      if (outst.size() > 0) begin
        h = outst[0];
        se.vld[h] = 1'b1;
        se.rdy    = d_rsp_ready[h];
        if (d_rsp_ready[h]) void'(outst.pop_front());
      end else begin
        se.rdy = 1'b1;
        exp_unx_q.push_back(cyc + 1);
      end
      exp_rsp_q.push_back(se);
    end

    if (g >= 0 && d_ready) begin
      locked = -1;
      last   = g;
      pend_v[g] = 1'b0;
      if (!pend_w[g]) outst.push_back(g);
    end

    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a handshake, response or pulse.
  req_exp_t m_re;
  rsp_exp_t m_se;
  int       m_ux;
  always @(negedge clk_i) begin
    if (mon_en) begin
      if ((|req_ready_o) || (snax_csr_req_valid_o && snax_csr_req_ready_i)) begin
        if (exp_req_q.size() == 0) check("req_unexpected_grant", {62'd0, req_ready_o}, 64'd0);
        else begin
          m_re = exp_req_q.pop_front();
          check("req_cycle", 64'(cyc), 64'(m_re.cyc));
          check("req_ready_o", {62'd0, req_ready_o}, 64'(1) << m_re.idx);
          check("req_valid_o", {63'd0, snax_csr_req_valid_o}, 64'd1);
          check("req_addr", {32'd0, snax_csr_req_bits_addr_o}, {32'd0, m_re.addr});
          check("req_data", {32'd0, snax_csr_req_bits_data_o}, {32'd0, m_re.data});
          check("req_write", {63'd0, snax_csr_req_bits_write_o}, {63'd0, m_re.wr});
        end
      end else if (exp_req_q.size() > 0 && exp_req_q[0].cyc <= cyc) begin
        void'(exp_req_q.pop_front());
        check("req_missing_handshake", 64'd0, 64'd1);
      end

      if (snax_csr_rsp_valid_i || (|rsp_valid_o)) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", {62'd0, rsp_valid_o}, 64'd0);
        else begin
          m_se = exp_rsp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(m_se.cyc));
          check("rsp_valid_o", {62'd0, rsp_valid_o}, {62'd0, m_se.vld});
          check("rsp_ready_o", {63'd0, snax_csr_rsp_ready_o}, {63'd0, m_se.rdy});
          if (m_se.vld != '0) check("rsp_data_o", {32'd0, rsp_data_o}, {32'd0, m_se.data});
        end
      end

      if (unexpected_rsp_o) begin
        if (exp_unx_q.size() == 0) check("unexpected_rsp_spurious", 64'd1, 64'd0);
        else begin
          m_ux = exp_unx_q.pop_front();
          check("unexpected_rsp_cycle", 64'(cyc), 64'(m_ux));
        end
      end else if (exp_unx_q.size() > 0 && exp_unx_q[0] <= cyc) begin
        void'(exp_unx_q.pop_front());
        check("unexpected_rsp_missing", 64'd0, 64'd1);
      end
    end
  end

  task automatic quiet();
    d_ready = 1'b0; d_rsp_valid = 1'b0; d_rsp_data = '0; d_rsp_ready = '0;
  endtask

  initial begin
    clear_model();
    // Reset with busy-looking inputs: every handshake output must still read zero.
    req_valid_i = '1; req_write_i = '0; req_addr_i = '1; req_data_i = '1;
    snax_csr_req_ready_i = 1'b1; snax_csr_rsp_valid_i = 1'b1;
    snax_csr_rsp_bits_data_i = 32'hFFFF_FFFF; rsp_ready_i = '1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req_ready_o", {62'd0, req_ready_o}, 64'd0);
    check("rst_req_valid_o", {63'd0, snax_csr_req_valid_o}, 64'd0);
    check("rst_rsp_valid_o", {62'd0, rsp_valid_o}, 64'd0);
    check("rst_rsp_data_o", {32'd0, rsp_data_o}, 64'd0);
    check("rst_rsp_ready_o", {63'd0, snax_csr_rsp_ready_o}, 64'd0);
    check("rst_unexpected", {63'd0, unexpected_rsp_o}, 64'd0);
    @(posedge clk_i);
    #1;
    quiet();
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Two readers, ready downstream: alternate grants until the tracker fills.
    d_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) set_req(i, 1'b0, $urandom, $urandom);
      step();
    end
    set_req(0, 1'b0, 32'h100, 32'h0);
    step();                                  // full: the read is withheld
    set_req(1, 1'b1, 32'h200, 32'h5555_AAAA);
    step();                                  // the write still passes
    d_rsp_valid = 1'b1; d_rsp_data = 32'hA0; d_rsp_ready = '1;
    step();                                  // first response pops
    d_rsp_valid = 1'b0;
    step();                                  // stalled read is accepted now
    for (int c = 0; c < 20 && outst.size() > 0; c++) begin
      d_rsp_valid = 1'b1; d_rsp_data = $urandom; d_rsp_ready = 2'($urandom);
      step();
    end
    quiet();
    step();

    // Locked write on requester 1 while downstream stalls.
    set_req(1, 1'b1, 32'h3c4, 32'hDEAD_BEEF);
    step();
    set_req(0, 1'b0, 32'h44, 32'h0);
    for (int c = 0; c < 2; c++) begin
      check("lock_addr", {32'd0, snax_csr_req_bits_addr_o}, 64'h3c4);
      check("lock_data", {32'd0, snax_csr_req_bits_data_o}, 64'hDEAD_BEEF);
      check("lock_ready", {62'd0, req_ready_o}, 64'd0);
      step();
    end
    d_ready = 1'b1;
    step();
    step();
    for (int c = 0; c < 6 && outst.size() > 0; c++) begin
      d_rsp_valid = 1'b1; d_rsp_data = $urandom; d_rsp_ready = '1;
      step();
    end
    quiet();
    step();

    // Responses routed in order, with requester 1 back-pressuring first.
    d_ready = 1'b1;
    set_req(1, 1'b0, 32'h10, 32'h0);
    step();
    set_req(0, 1'b0, 32'h20, 32'h0);
    step();
    d_ready = 1'b0;
    d_rsp_valid = 1'b1; d_rsp_data = 32'h11; d_rsp_ready = 2'b01;
    step();
    d_rsp_ready = 2'b11;
    step();
    d_rsp_data = 32'h22;
    step();

    // Orphan response on an empty tracker.
    d_rsp_data = 32'h33;
    step();
    quiet();
    check("orphan_pulse_high", {63'd0, unexpected_rsp_o}, 64'd1);
    step();
    check("orphan_pulse_low", {63'd0, unexpected_rsp_o}, 64'd0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(99) < 40) set_req(i, 1'($urandom), $urandom, $urandom);
      d_ready     = ($urandom_range(99) < 60);
      d_rsp_valid = (outst.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 5);
      d_rsp_data  = $urandom;
      d_rsp_ready = 2'($urandom);
      step();
    end
    for (int c = 0; c < 30; c++) begin
      d_ready = 1'b1; d_rsp_valid = (outst.size() > 0); d_rsp_data = $urandom; d_rsp_ready = '1;
      step();
    end
    quiet();
    step();

    // Reset with two reads in flight, then an orphan response.
    d_ready = 1'b1;
    set_req(0, 1'b0, 32'h30, 32'h0);
    set_req(1, 1'b0, 32'h34, 32'h0);
    step();
    step();
    quiet();
    step();
    mon_en = 1'b0;
    rst_ni = 1'b0;
    clear_model();
    @(negedge clk_i);
    check("midrst_rsp_ready_o", {63'd0, snax_csr_rsp_ready_o}, 64'd0);
    check("midrst_req_valid_o", {63'd0, snax_csr_req_valid_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;
    d_rsp_valid = 1'b1; d_rsp_data = 32'h77; d_rsp_ready = 2'b00;
    step();
    quiet();
    check("post_reset_orphan", {63'd0, unexpected_rsp_o}, 64'd1);
    step();
    step();

    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);
    check("unexpected_queue_drained", 64'(exp_unx_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
